// File: rtl/icmp_pkg.sv
// rtl/icmp_pkg.sv - shared constants and state encoding for the ICMP echo responder
package icmp_pkg;

  localparam logic [7:0]  ICMP_ECHO_REQ   = 8'd8;
  localparam logic [7:0]  ICMP_ECHO_REPLY = 8'd0;
  localparam int          IP_HDR_LEN      = 20;
  localparam int          ICMP_MIN_LEN    = 8;
  localparam logic [7:0]  IP_PROTO_ICMP   = 8'd1;
  localparam logic [15:0] CSUM_DELTA      = 16'h0800;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    DROP
  } state_e;

endpackage

// File: rtl/icmp_rate_limiter.sv
// rtl/icmp_rate_limiter.sv - per-window reply budget, built only with ICMP_RATE_LIMIT_EN
`ifdef ICMP_RATE_LIMIT_EN
module icmp_rate_limiter #(
  parameter int RATE_WINDOW = 125000000,
  parameter int RATE_MAX    = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic consume,
  output logic allow
);

  localparam int WIN_W = $clog2(RATE_WINDOW);
  localparam int BUD_W = $clog2(RATE_MAX + 1);

  logic [WIN_W-1:0] win_q;
  logic [BUD_W-1:0] budget_q;
  logic             wrap;

  assign wrap  = (win_q == WIN_W'(RATE_WINDOW - 1));
  // A wrap in this cycle refills the budget before the request is charged.
  assign allow = wrap || (budget_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '0;
      budget_q <= BUD_W'(RATE_MAX);
    end else begin
      win_q <= wrap ? '0 : win_q + WIN_W'(1);
      if (wrap)
        budget_q <= consume ? BUD_W'(RATE_MAX - 1) : BUD_W'(RATE_MAX);
      else if (consume && budget_q != '0)
        budget_q <= budget_q - BUD_W'(1);
    end
  end

endmodule
`endif

// File: rtl/icmp_echo_responder.sv
// rtl/icmp_echo_responder.sv - ICMP echo responder on the IP payload interfaces
// Reply rate limiting is compiled in when ICMP_RATE_LIMIT_EN is defined.
module icmp_echo_responder
  import icmp_pkg::*;
#(
  parameter int NUM_IP      = 4,
  parameter int CNT_W       = 24,
  parameter int TTL         = 64,
  parameter int RATE_WINDOW = 125000000,
  parameter int RATE_MAX    = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [32*NUM_IP-1:0] local_ip,
  input  logic [NUM_IP-1:0]    local_ip_en,
  input  logic                 s_ip_hdr_valid,
  output logic                 s_ip_hdr_ready,
  input  logic [15:0]          s_ip_length,
  input  logic [31:0]          s_ip_source_ip,
  input  logic [31:0]          s_ip_dest_ip,
  input  logic [7:0]           s_payload_tdata,
  input  logic                 s_payload_tvalid,
  output logic                 s_payload_tready,
  input  logic                 s_payload_tlast,
  output logic                 m_ip_hdr_valid,
  input  logic                 m_ip_hdr_ready,
  output logic [15:0]          m_ip_length,
  output logic [7:0]           m_ip_ttl,
  output logic [7:0]           m_ip_protocol,
  output logic [5:0]           m_ip_dscp,
  output logic [1:0]           m_ip_ecn,
  output logic [31:0]          m_ip_source_ip,
  output logic [31:0]          m_ip_dest_ip,
  output logic [7:0]           m_payload_tdata,
  output logic                 m_payload_tvalid,
  input  logic                 m_payload_tready,
  output logic                 m_payload_tlast,
  output logic                 m_payload_tuser,
  input  logic                 clear_counter,
  output logic [CNT_W-1:0]     echo_cnt,
  output logic [CNT_W-1:0]     drop_not_local_cnt,
  output logic [CNT_W-1:0]     drop_not_echo_cnt,
  output logic [CNT_W-1:0]     drop_runt_cnt,
  output logic [CNT_W-1:0]     drop_rate_cnt
);

  state_e           state_q;
  logic [2:0]       idx_q;
  logic             phase_q;
  logic [7:0]       hi_q;
  logic             hdr_valid_q;
  logic [15:0]      len_q;
  logic [31:0]      src_q, dst_q;
  logic [CNT_W-1:0] echo_q, not_local_q, not_echo_q, runt_q;

  logic accept, is_local, is_runt, is_echo, rate_ok, do_reply;
  logic s_hs, trunc;
  logic [16:0] sum17;
  logic [15:0] csum;

  always_comb begin
    is_local = 1'b0;
    for (int i = 0; i < NUM_IP; i++)
      if (local_ip_en[i] && local_ip[32*i +: 32] == s_ip_dest_ip) is_local = 1'b1;
  end

  assign accept         = (state_q == IDLE) && s_ip_hdr_valid && s_payload_tvalid;
  assign s_ip_hdr_ready = accept;
  assign is_runt        = s_ip_length < 16'(IP_HDR_LEN + ICMP_MIN_LEN);
  assign is_echo        = (s_payload_tdata == ICMP_ECHO_REQ);
  assign do_reply       = is_local && !is_runt && is_echo && rate_ok;

  // Type 8 -> 0 raises the checksum word by 0x0800 with end-around carry.
  assign sum17 = {1'b0, hi_q, s_payload_tdata} + {1'b0, CSUM_DELTA};
  assign csum  = sum17[15:0] + {15'd0, sum17[16]};

  always_comb begin
    m_payload_tdata  = s_payload_tdata;
    m_payload_tvalid = 1'b0;
    m_payload_tlast  = 1'b0;
    m_payload_tuser  = 1'b0;
    s_payload_tready = 1'b0;
    case (state_q)
      DROP: s_payload_tready = 1'b1;
      PAY: begin
        m_payload_tvalid = s_payload_tvalid;
        m_payload_tlast  = s_payload_tlast;
        s_payload_tready = m_payload_tready;
        if (idx_q <= 3'd2) m_payload_tuser = s_payload_tlast;
        if (idx_q == 3'd0) begin
          m_payload_tdata = ICMP_ECHO_REPLY;
        end else if (idx_q == 3'd2 && !s_payload_tlast) begin
          m_payload_tvalid = 1'b0;
          s_payload_tready = 1'b1;
        end else if (idx_q == 3'd3) begin
          if (!phase_q) begin
            m_payload_tdata  = csum[15:8];
            m_payload_tlast  = 1'b0;
            s_payload_tready = 1'b0;
          end else begin
            m_payload_tdata = csum[7:0];
          end
        end
      end
      default: ;
    endcase
  end

  assign s_hs  = s_payload_tvalid && s_payload_tready;
  assign trunc = (state_q == PAY) && s_hs && s_payload_tlast && (idx_q <= 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      hdr_valid_q <= 1'b0;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          len_q   <= s_ip_length;
          src_q   <= s_ip_source_ip;
          dst_q   <= s_ip_dest_ip;
          idx_q   <= '0;
          phase_q <= 1'b0;
          if (do_reply) begin
            state_q     <= HDR;
            hdr_valid_q <= 1'b1;
          end else begin
            state_q <= DROP;
          end
        end
        HDR: if (m_ip_hdr_ready) begin
          hdr_valid_q <= 1'b0;
          state_q     <= PAY;
        end
        PAY: begin
          if (idx_q == 3'd3 && !phase_q && s_payload_tvalid && m_payload_tready) phase_q <= 1'b1;
          if (s_hs) begin
            if (idx_q == 3'd2) hi_q <= s_payload_tdata;
            if (idx_q != 3'd4) idx_q <= idx_q + 3'd1;
            if (s_payload_tlast) state_q <= IDLE;
          end
        end
        DROP: if (s_hs && s_payload_tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != '1) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear_counter) begin
      echo_q      <= '0;
      not_local_q <= '0;
      not_echo_q  <= '0;
      runt_q      <= '0;
    end else begin
      echo_q      <= sat_inc(echo_q, accept && do_reply);
      not_local_q <= sat_inc(not_local_q, accept && !is_local);
      not_echo_q  <= sat_inc(not_echo_q, accept && is_local && !is_runt && !is_echo);
      runt_q      <= sat_inc(runt_q, (accept && is_local && is_runt) || trunc);
    end
  end

`ifdef ICMP_RATE_LIMIT_EN
  logic             rate_allow;
  logic [CNT_W-1:0] rate_q;

  icmp_rate_limiter #(
    .RATE_WINDOW(RATE_WINDOW),
    .RATE_MAX   (RATE_MAX)
  ) u_rate (
    .clk    (clk),
    .rst    (rst),
    .consume(accept && do_reply),
    .allow  (rate_allow)
  );

  assign rate_ok = rate_allow;

  always_ff @(posedge clk) begin
    if (rst || clear_counter)
      rate_q <= '0;
    else
      rate_q <= sat_inc(rate_q, accept && is_local && !is_runt && is_echo && !rate_ok);
  end

  assign drop_rate_cnt = rate_q;
`else
  logic unused_rate;
  assign rate_ok       = 1'b1;
  assign drop_rate_cnt = '0;
  assign unused_rate   = ^{RATE_WINDOW[0], RATE_MAX[0]};
`endif

  assign m_ip_hdr_valid     = hdr_valid_q;
  assign m_ip_length        = len_q;
  assign m_ip_ttl           = 8'(TTL);
  assign m_ip_protocol      = IP_PROTO_ICMP;
  assign m_ip_dscp          = '0;
  assign m_ip_ecn           = '0;
  assign m_ip_source_ip     = dst_q;
  assign m_ip_dest_ip       = src_q;
  assign echo_cnt           = echo_q;
  assign drop_not_local_cnt = not_local_q;
  assign drop_not_echo_cnt  = not_echo_q;
  assign drop_runt_cnt      = runt_q;

endmodule

// File: tb/tb_icmp_echo_responder.sv
// tb/tb_icmp_echo_responder.sv - directed and table-driven bench for icmp_echo_responder
module tb_icmp_echo_responder;

  localparam logic [31:0] IP0    = 32'h0A000001;
  localparam logic [31:0] IP1    = 32'hC0A80109;
  localparam logic [31:0] IP2    = 32'hC0A8010A;
  localparam logic [31:0] IP3    = 32'h0A000002;
  localparam logic [31:0] SRC_IP = 32'hC0A80164;

  logic        clk = 1'b0;
  logic        rst;
  logic [127:0] local_ip;
  logic [3:0]  local_ip_en;
  logic        s_ip_hdr_valid, s_ip_hdr_ready;
  logic [15:0] s_ip_length;
  logic [31:0] s_ip_source_ip, s_ip_dest_ip;
  logic [7:0]  s_payload_tdata;
  logic        s_payload_tvalid, s_payload_tready, s_payload_tlast;
  logic        m_ip_hdr_valid, m_ip_hdr_ready;
  logic [15:0] m_ip_length;
  logic [7:0]  m_ip_ttl, m_ip_protocol;
  logic [5:0]  m_ip_dscp;
  logic [1:0]  m_ip_ecn;
  logic [31:0] m_ip_source_ip, m_ip_dest_ip;
  logic [7:0]  m_payload_tdata;
  logic        m_payload_tvalid, m_payload_tready, m_payload_tlast, m_payload_tuser;
  logic        clear_counter;
  logic [23:0] echo_cnt, drop_not_local_cnt, drop_not_echo_cnt, drop_runt_cnt, drop_rate_cnt;

  icmp_echo_responder #(
    .NUM_IP(4), .CNT_W(24), .TTL(64), .RATE_WINDOW(1000), .RATE_MAX(2)
  ) dut (
    .clk(clk), .rst(rst), .local_ip(local_ip), .local_ip_en(local_ip_en),
    .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
    .s_ip_length(s_ip_length), .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
    .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid),
    .s_payload_tready(s_payload_tready), .s_payload_tlast(s_payload_tlast),
    .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
    .m_ip_length(m_ip_length), .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_payload_tdata(m_payload_tdata), .m_payload_tvalid(m_payload_tvalid),
    .m_payload_tready(m_payload_tready), .m_payload_tlast(m_payload_tlast),
    .m_payload_tuser(m_payload_tuser), .clear_counter(clear_counter),
    .echo_cnt(echo_cnt), .drop_not_local_cnt(drop_not_local_cnt),
    .drop_not_echo_cnt(drop_not_echo_cnt), .drop_runt_cnt(drop_runt_cnt),
    .drop_rate_cnt(drop_rate_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic [31:0] dst;
    logic [15:0] len;
    logic [7:0]  typ;
    logic [15:0] csum;
    int          cls;    // 0 reply, 1 not local, 2 runt, 3 not echo, 4 rate
    logic [15:0] ecs;
  } vec_t;

  int checks = 0, errors = 0;
  int e_echo = 0, e_nl = 0, e_ne = 0, e_runt = 0, e_rate = 0;
  logic [7:0] req_b[64];
  logic [9:0] exp_q[$], act_q[$];
  int hdr_seen = 0;
  logic [31:0] hdr_src, hdr_dst;
  logic [15:0] hdr_len;
  bit bp = 1'b0;
  logic prev_stall = 1'b0;
  logic [9:0] prev_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    m_payload_tready = 1'b1;
    m_ip_hdr_ready   = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_payload_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ip_hdr_ready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (prev_stall)
        check("stall_hold", {m_payload_tvalid, m_payload_tuser, m_payload_tlast, m_payload_tdata},
              {1'b1, prev_beat});
      prev_stall = m_payload_tvalid && !m_payload_tready;
      prev_beat  = {m_payload_tuser, m_payload_tlast, m_payload_tdata};
      if (m_payload_tvalid && m_payload_tready)
        act_q.push_back({m_payload_tuser, m_payload_tlast, m_payload_tdata});
      if (m_ip_hdr_valid && m_ip_hdr_ready) begin
        hdr_seen++;
        hdr_src = m_ip_source_ip;
        hdr_dst = m_ip_dest_ip;
        hdr_len = m_ip_length;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input bit hdr, input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (hdr ? s_ip_hdr_ready : s_payload_tready) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL timeout_%s actual=no_ready expected=ready", name);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic build_req(input logic [7:0] typ, input logic [7:0] code, input logic [15:0] cs,
                           input logic [7:0] seed);
    req_b[0] = typ;
    req_b[1] = code;
    req_b[2] = cs[15:8];
    req_b[3] = cs[7:0];
    for (int i = 4; i < 64; i++) req_b[i] = 8'(i * 13) ^ seed;
  endtask

  task automatic send_frame(input logic [31:0] dst, input logic [15:0] len, input int n,
                            input bit clr, input bit exp_hdr);
    s_ip_hdr_valid   = 1'b1;
    s_ip_length      = len;
    s_ip_source_ip   = SRC_IP;
    s_ip_dest_ip     = dst;
    s_payload_tdata  = req_b[0];
    s_payload_tvalid = 1'b1;
    s_payload_tlast  = (n == 1);
    clear_counter    = clr;
    wait_ready(1'b1, "hdr");
    s_ip_hdr_valid = 1'b0;
    clear_counter  = 1'b0;
    check("hdr_valid_next", m_ip_hdr_valid, exp_hdr);
    for (int i = 0; i < n; i++) begin
      s_payload_tdata  = req_b[i];
      s_payload_tvalid = 1'b1;
      s_payload_tlast  = (i == n - 1);
      wait_ready(1'b0, "pay");
    end
    s_payload_tvalid = 1'b0;
    s_payload_tlast  = 1'b0;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_echo_cnt"}, echo_cnt, e_echo);
    check({tag, "_not_local_cnt"}, drop_not_local_cnt, e_nl);
    check({tag, "_not_echo_cnt"}, drop_not_echo_cnt, e_ne);
    check({tag, "_runt_cnt"}, drop_runt_cnt, e_runt);
    check({tag, "_rate_cnt"}, drop_rate_cnt, e_rate);
  endtask

  task automatic run_one(input string tag, input logic [31:0] dst, input logic [15:0] len,
                         input int n, input int cls, input logic [15:0] ecs, input bit clr);
    int h0;
    exp_q.delete();
    act_q.delete();
    h0 = hdr_seen;
    if (cls == 0)
      for (int i = 0; i < n; i++) begin
        logic [7:0] d;
        d = req_b[i];
        if (i == 0) d = 8'h00;
        else if (i == 2 && n > 3) d = ecs[15:8];
        else if (i == 3) d = ecs[7:0];
        exp_q.push_back({(n <= 3 && i == n - 1), (i == n - 1), d});
      end
    case (cls)
      0: begin e_echo++; if (n <= 3) e_runt++; end
      1: e_nl++;
      2: e_runt++;
      3: e_ne++;
      default: e_rate++;
    endcase
    if (clr) begin e_echo = 0; e_nl = 0; e_ne = 0; e_runt = 0; e_rate = 0; end
    send_frame(dst, len, n, clr, cls == 0);
    check({tag, "_hdr_count"}, hdr_seen - h0, (cls == 0) ? 1 : 0);
    if (cls == 0) begin
      check({tag, "_reply_src"}, hdr_src, dst);
      check({tag, "_reply_dst"}, hdr_dst, SRC_IP);
      check({tag, "_reply_len"}, hdr_len, len);
    end
    check({tag, "_beats"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), act_q[i], exp_q[i]);
    check_cnts(tag);
  endtask

  initial begin
    vec_t vt[12];
    vt[0]  = '{4'b0100, IP2, 16'd60, 8'd8,  16'h1234, 0, 16'h1A34};
    vt[1]  = '{4'b0100, IP2, 16'd60, 8'd8,  16'hF8FF, 0, 16'h0100};
    vt[2]  = '{4'b0100, IP1, 16'd60, 8'd8,  16'h1234, 1, 16'h0000};
    vt[3]  = '{4'b0100, IP2, 16'd60, 8'd13, 16'h1234, 3, 16'h0000};
    vt[4]  = '{4'b0100, IP2, 16'd24, 8'd8,  16'h1234, 2, 16'h0000};
    vt[5]  = '{4'b1111, IP0, 16'd28, 8'd8,  16'hFFFF, 0, 16'h0800};
    vt[6]  = '{4'b1111, IP0, 16'd27, 8'd8,  16'h1234, 2, 16'h0000};
    vt[7]  = '{4'b1111, IP3, 16'd29, 8'd8,  16'hF7FF, 0, 16'hFFFF};
    vt[8]  = '{4'b1000, IP3, 16'd40, 8'd8,  16'hF800, 0, 16'h0001};
    vt[9]  = '{4'b0000, IP0, 16'd60, 8'd8,  16'h1234, 1, 16'h0000};
    vt[10] = '{4'b0100, IP0, 16'd22, 8'd13, 16'h1234, 1, 16'h0000};
    vt[11] = '{4'b0100, IP2, 16'd22, 8'd0,  16'h1234, 2, 16'h0000};

    rst = 1'b1;
    local_ip = {IP3, IP2, IP1, IP0};
    local_ip_en = 4'b0100;
    s_ip_hdr_valid = 1'b0; s_ip_length = '0; s_ip_source_ip = '0; s_ip_dest_ip = '0;
    s_payload_tdata = '0; s_payload_tvalid = 1'b0; s_payload_tlast = 1'b0;
    clear_counter = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hdr_valid", m_ip_hdr_valid, 1'b0);
    check("rst_m_tvalid", m_payload_tvalid, 1'b0);
    check("rst_s_tready", s_payload_tready, 1'b0);
    check("rst_hdr_ready", s_ip_hdr_ready, 1'b0);
    check("rst_m_len", m_ip_length, 16'd0);
    check("rst_m_src", m_ip_source_ip, 32'd0);
    check("rst_ttl", m_ip_ttl, 8'd64);
    check("rst_proto", m_ip_protocol, 8'd1);
    check("rst_dscp_ecn", {m_ip_dscp, m_ip_ecn}, 8'd0);
    check_cnts("rst");
    @(posedge clk); #1;

    for (int v = 0; v < 12; v++) begin
      int n;
      n = (vt[v].len > 16'd20) ? int'(vt[v].len) - 20 : 1;
      build_req(vt[v].typ, 8'h5A + 8'(v), vt[v].csum, 8'(v));
      local_ip_en = vt[v].en;
      run_one($sformatf("vec%0d", v), vt[v].dst, vt[v].len, n, vt[v].cls, vt[v].ecs, 1'b0);
    end

    local_ip_en = 4'b0100;
    build_req(8'd13, 8'h00, 16'h1234, 8'h11);
    run_one("clear_vs_inc", IP2, 16'd40, 20, 3, 16'h0000, 1'b1);

    build_req(8'd8, 8'h77, 16'h1234, 8'h22);
    run_one("trunc_idx2", IP2, 16'd60, 3, 0, 16'h0000, 1'b0);
    build_req(8'd8, 8'h78, 16'h1234, 8'h23);
    run_one("trunc_idx0", IP2, 16'd60, 1, 0, 16'h0000, 1'b0);
    build_req(8'd8, 8'h79, 16'h1234, 8'h24);
    run_one("after_trunc", IP2, 16'd60, 40, 0, 16'h1A34, 1'b0);

    bp = 1'b1;
    for (int k = 0; k < 100; k++) begin
      int len, s;
      logic [15:0] cs;
      len = $urandom_range(28, 60);
      cs  = 16'($urandom);
      s   = int'(cs) + 32'h0800;
      if (s > 32'hFFFF) s = s - 32'hFFFF;
      build_req(8'd8, 8'($urandom), cs, 8'(k));
      run_one($sformatf("bp%0d", k), IP2, 16'(len), len - 20, 0, 16'(s), 1'b0);
    end
    bp = 1'b0;

`ifdef ICMP_RATE_LIMIT_EN
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e_echo = 0; e_nl = 0; e_ne = 0; e_runt = 0; e_rate = 0;
    for (int k = 0; k < 5; k++) begin
      build_req(8'd8, 8'h01, 16'h1234, 8'(k));
      run_one($sformatf("rate%0d", k), IP2, 16'd28, 8, (k < 2) ? 0 : 4, 16'h1A34, 1'b0);
    end
    repeat (1000) @(posedge clk);
    #1;
    build_req(8'd8, 8'h02, 16'h1234, 8'h33);
    run_one("rate_after_wrap", IP2, 16'd28, 8, 0, 16'h1A34, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
